// File: rtl/ram2e_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : ram2e_cmd_seq
// Purpose  : Command-sequence decoder for the RAM2E settings/UFM block.
//            Watches writes to the RAMWorks bank register for a 6-byte key,
//            then tracks one command byte and one argument byte. It drives
//            CS and the CmdRWMaskSet/CmdLEDSet strobes, which the UFM block
//            samples during S==C.
// Options  : RAM2E_CMD_TIMEOUT_EN - when defined, abandons a partial
//            sequence after TIMEOUT_CYC idle 1 MHz cycles.
// Revision : 1.0 - initial release
// ============================================================================
module ram2e_cmd_seq #(
  parameter logic [7:0]  KEY0        = 8'hFF,
  parameter logic [7:0]  KEY1        = 8'h00,
  parameter logic [7:0]  KEY2        = 8'h55,
  parameter logic [7:0]  KEY3        = 8'hAA,
  parameter logic [7:0]  KEY4        = 8'hC1,
  parameter logic [7:0]  KEY5        = 8'hAD,
  parameter logic [7:0]  CMD_RWMASK  = 8'h2A,
  parameter logic [7:0]  CMD_LED     = 8'h28,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
  input  logic       C14M,
  input  logic       Reset,
  input  logic [3:0] S,
  input  logic       RWSel,
  input  logic [7:0] D,
  output logic [2:0] CS,
  output logic       CmdRWMaskSet,
  output logic       CmdLEDSet
);

  // Sequence position: CS_IDLE..CS_K5 expect key bytes 0..5,
  // CS_CMD expects the command byte, CS_ARG the argument byte.
  typedef enum logic [2:0] {
    CS_IDLE = 3'd0,
    CS_K1   = 3'd1,
    CS_K2   = 3'd2,
    CS_K3   = 3'd3,
    CS_K4   = 3'd4,
    CS_K5   = 3'd5,
    CS_CMD  = 3'd6,
    CS_ARG  = 3'd7
  } cs_t;

  cs_t  state;
  logic cmd_rwmask;
  logic cmd_led;
  logic qual_write;
  logic timeout_hit;

  // Only a bank-register write at the end of S==C advances the sequence.
  assign qual_write = RWSel && (S == 4'hC);

  // Key byte expected in each key-matching state.
  function automatic logic [7:0] key_for(input cs_t st);
    case (st)
      CS_IDLE: key_for = KEY0;
      CS_K1:   key_for = KEY1;
      CS_K2:   key_for = KEY2;
      CS_K3:   key_for = KEY3;
      CS_K4:   key_for = KEY4;
      CS_K5:   key_for = KEY5;
      default: key_for = KEY0;
    endcase
  endfunction

  // Successor state after a correct key byte.
  function automatic cs_t key_advance(input cs_t st);
    case (st)
      CS_IDLE: key_advance = CS_K1;
      CS_K1:   key_advance = CS_K2;
      CS_K2:   key_advance = CS_K3;
      CS_K3:   key_advance = CS_K4;
      CS_K4:   key_advance = CS_K5;
      CS_K5:   key_advance = CS_CMD;
      default: key_advance = CS_IDLE;
    endcase
  endfunction

`ifdef RAM2E_CMD_TIMEOUT_EN
  logic [15:0] idle_cnt;

  // Abort fires on the S==0 edge that would complete TIMEOUT_CYC idle cycles.
  assign timeout_hit = (S == 4'h0) && (state != CS_IDLE) &&
                       (idle_cnt == TIMEOUT_CYC - 16'd1);

  // Idle 1 MHz cycle counter: cleared by any qualifying write or while idle, saturating.
  always_ff @(posedge C14M or posedge Reset) begin
    if (Reset) begin
      idle_cnt <= 16'd0;
    end else if (qual_write || (state == CS_IDLE) || timeout_hit) begin
      idle_cnt <= 16'd0;
    end else if ((S == 4'h0) && (idle_cnt != 16'hFFFF)) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  // Without the timeout a partial sequence waits indefinitely for the next write.
  logic [15:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  // Sequence FSM; outputs are registered so they hold steady through S==C.
  always_ff @(posedge C14M or posedge Reset) begin
    if (Reset) begin
      state      <= CS_IDLE;
      cmd_rwmask <= 1'b0;
      cmd_led    <= 1'b0;
    end else if (timeout_hit) begin
      state      <= CS_IDLE;
      cmd_rwmask <= 1'b0;
      cmd_led    <= 1'b0;
    end else if (qual_write) begin
      case (state)
        CS_CMD: begin
          cmd_rwmask <= (D == CMD_RWMASK);
          cmd_led    <= (D == CMD_LED);
          state      <= ((D == CMD_RWMASK) || (D == CMD_LED)) ? CS_ARG : CS_IDLE;
        end
        CS_ARG: begin
          // The consumer used the strobes during this S==C; retire them now.
          cmd_rwmask <= 1'b0;
          cmd_led    <= 1'b0;
          state      <= CS_IDLE;
        end
        default: begin
          // A wrong byte that is itself KEY0 counts as the start of a new key.
          if (D == key_for(state)) begin
            state <= key_advance(state);
          end else if (D == KEY0) begin
            state <= CS_K1;
          end else begin
            state <= CS_IDLE;
          end
        end
      endcase
    end
  end

  assign CS           = state;
  assign CmdRWMaskSet = cmd_rwmask;
  assign CmdLEDSet    = cmd_led;

`ifndef SYNTHESIS
  a_cmd_exclusive: assert property (@(posedge C14M) disable iff (Reset)
    !(cmd_rwmask && cmd_led));
  a_cmd_only_in_arg: assert property (@(posedge C14M) disable iff (Reset)
    ((state == CS_ARG) == (cmd_rwmask || cmd_led)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram2e_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram2e_cmd_seq
// Purpose  : Self-checking bench for ram2e_cmd_seq with a behavioural model
//            of the key/command/argument protocol. Honours
//            RAM2E_CMD_TIMEOUT_EN (DUT built with TIMEOUT_CYC = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram2e_cmd_seq;

  localparam int TO = 4;

  logic       C14M = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] S = 4'h0;
  logic       RWSel = 1'b0;
  logic [7:0] D = 8'h00;
  logic [2:0] CS;
  logic       CmdRWMaskSet;
  logic       CmdLEDSet;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_cs;
  bit m_rw;
  bit m_led;
  int m_idle;
  logic [7:0] keys [0:5] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hC1, 8'hAD};

  ram2e_cmd_seq #(.TIMEOUT_CYC(16'(TO))) dut (
    .C14M         (C14M),
    .Reset        (Reset),
    .S            (S),
    .RWSel        (RWSel),
    .D            (D),
    .CS           (CS),
    .CmdRWMaskSet (CmdRWMaskSet),
    .CmdLEDSet    (CmdLEDSet)
  );

  always #5 C14M = ~C14M;

  task automatic model_reset();
    m_cs = 0; m_rw = 0; m_led = 0; m_idle = 0;
  endtask

  // Protocol rules: key bytes in order, KEY0 restarts, then command, then argument.
  task automatic model_write(input logic [7:0] d);
    if (m_cs < 6) begin
      if (d == keys[m_cs]) m_cs = m_cs + 1;
      else if (d == keys[0]) m_cs = 1;
      else m_cs = 0;
    end else if (m_cs == 6) begin
      m_rw  = (d == 8'h2A);
      m_led = (d == 8'h28);
      m_cs  = (m_rw || m_led) ? 7 : 0;
    end else begin
      m_cs = 0; m_rw = 0; m_led = 0;
    end
    m_idle = 0;
  endtask

  // One S==0 edge: counts idle 1 MHz cycles when a timeout is configured.
  task automatic model_s0_edge();
`ifdef RAM2E_CMD_TIMEOUT_EN
    if (m_cs == 0) m_idle = 0;
    else if (m_idle == TO - 1) begin
      m_cs = 0; m_rw = 0; m_led = 0; m_idle = 0;
    end else if (m_idle < 65535) m_idle = m_idle + 1;
`endif
  endtask

  // Drives one full 1 MHz cycle (S=0..F); reports phases where outputs differ from the model.
  task automatic bus_cycle(input bit wr, input logic [7:0] data, input bit noise,
                           output int bad, output logic [4:0] got, output logic [4:0] exp);
    bad = 0; got = '0; exp = '0;
    for (int s = 0; s < 16; s++) begin
      S = 4'(s);
      if (s == 12) begin
        RWSel = wr;
        D     = data;
      end else begin
        RWSel = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        D     = 8'($urandom);
      end
      if ({CS, CmdRWMaskSet, CmdLEDSet} !== {3'(m_cs), m_rw, m_led}) begin
        if (bad == 0) begin
          got = {CS, CmdRWMaskSet, CmdLEDSet};
          exp = {3'(m_cs), m_rw, m_led};
        end
        bad++;
      end
      @(posedge C14M);
      if (s == 12 && wr) model_write(data);
      if (s == 0) model_s0_edge();
      #1;
    end
    RWSel = 1'b0;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    RWSel = 1'b0;
    S     = 4'h0;
    repeat (2) @(posedge C14M);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge C14M);
    #1;
    checks++;
    if ({CS, CmdRWMaskSet, CmdLEDSet} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: got CS=%0d rw=%b led=%b want 0/0/0", CS, CmdRWMaskSet, CmdLEDSet);
    end
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_rwmask();
    logic [7:0] seq [0:7] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hC1, 8'hAD, 8'h2A, 8'h5C};
    logic [2:0] want [0:7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    int bad; logic [4:0] got, exp;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      bus_cycle(1'b1, seq[i], 1'b0, bad, got, exp);
      checks++;
      if (bad != 0 || CS !== want[i]) begin
        errors++;
        $display("FAIL rwmask_step%0d: got CS=%0d (%0d bad phases, first %b vs %b) want CS=%0d",
                 i, CS, bad, got, exp, want[i]);
      end
      if (i == 6) begin
        checks++;
        if (CmdRWMaskSet !== 1'b1 || CmdLEDSet !== 1'b0) begin
          errors++;
          $display("FAIL rwmask_armed: got rw=%b led=%b want rw=1 led=0", CmdRWMaskSet, CmdLEDSet);
        end
      end
    end
    checks++;
    if (CmdRWMaskSet !== 1'b0 || CmdLEDSet !== 1'b0) begin
      errors++;
      $display("FAIL rwmask_retire: got rw=%b led=%b want 0/0", CmdRWMaskSet, CmdLEDSet);
    end
  endtask

  task automatic test_led();
    logic [7:0] seq [0:7] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hC1, 8'hAD, 8'h28, 8'h01};
    int bad; logic [4:0] got, exp;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      bus_cycle(1'b1, seq[i], 1'b1, bad, got, exp);
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL led_step%0d: got %b want %b (%0d bad phases)", i, got, exp, bad);
      end
      if (i == 6) begin
        checks++;
        if (CS !== 3'd7 || CmdLEDSet !== 1'b1 || CmdRWMaskSet !== 1'b0) begin
          errors++;
          $display("FAIL led_armed: got CS=%0d rw=%b led=%b want 7/0/1", CS, CmdRWMaskSet, CmdLEDSet);
        end
      end
    end
    checks++;
    if ({CS, CmdRWMaskSet, CmdLEDSet} !== 5'b0) begin
      errors++;
      $display("FAIL led_retire: got CS=%0d rw=%b led=%b want 0/0/0", CS, CmdRWMaskSet, CmdLEDSet);
    end
  endtask

  task automatic test_bad_cmd();
    int bad; logic [4:0] got, exp;
    apply_reset();
    for (int i = 0; i < 6; i++) bus_cycle(1'b1, keys[i], 1'b0, bad, got, exp);
    checks++;
    if (CS !== 3'd6) begin
      errors++;
      $display("FAIL badcmd_key: got CS=%0d want 6", CS);
    end
    bus_cycle(1'b1, 8'hEA, 1'b0, bad, got, exp);
    checks++;
    if ({CS, CmdRWMaskSet, CmdLEDSet} !== 5'b0) begin
      errors++;
      $display("FAIL badcmd_abort: got CS=%0d rw=%b led=%b want 0/0/0", CS, CmdRWMaskSet, CmdLEDSet);
    end
    // Park at CS=3, then hammer writes in every phase except S==C.
    for (int i = 0; i < 3; i++) bus_cycle(1'b1, keys[i], 1'b0, bad, got, exp);
    for (int i = 0; i < 3; i++) begin
      bus_cycle(1'b0, keys[3], 1'b1, bad, got, exp);
      checks++;
      if (bad != 0 || CS !== 3'd3) begin
`ifdef RAM2E_CMD_TIMEOUT_EN
        if (!(bad == 0 && i == 2)) begin
`else
        begin
`endif
          errors++;
          $display("FAIL sweep_%0d: got CS=%0d (%0d bad phases) want CS=3", i, CS, bad);
        end
      end
    end
  endtask

  task automatic test_restart();
    logic [7:0] seq [0:8] = '{8'hFF, 8'h00, 8'h55, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'hC1, 8'hAD};
    logic [2:0] want [0:8] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    int bad; logic [4:0] got, exp;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      bus_cycle(1'b1, seq[i], 1'b0, bad, got, exp);
      checks++;
      if (bad != 0 || CS !== want[i]) begin
        errors++;
        $display("FAIL restart_step%0d: got CS=%0d want CS=%0d", i, CS, want[i]);
      end
    end
    // At CS=1 a second FF stays at CS=1.
    apply_reset();
    bus_cycle(1'b1, 8'hFF, 1'b0, bad, got, exp);
    bus_cycle(1'b1, 8'hFF, 1'b0, bad, got, exp);
    checks++;
    if (CS !== 3'd1) begin
      errors++;
      $display("FAIL restart_ff_ff: got CS=%0d want 1", CS);
    end
  endtask

  task automatic test_async_reset();
    int bad; logic [4:0] got, exp;
    apply_reset();
    for (int i = 0; i < 6; i++) bus_cycle(1'b1, keys[i], 1'b0, bad, got, exp);
    bus_cycle(1'b1, 8'h28, 1'b0, bad, got, exp);
    for (int s = 0; s < 3; s++) begin
      S = 4'(s);
      @(posedge C14M);
      #1;
    end
    checks++;
    if (CS !== 3'd7 || CmdLEDSet !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got CS=%0d led=%b want 7/1", CS, CmdLEDSet);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({CS, CmdRWMaskSet, CmdLEDSet} !== 5'b0) begin
      errors++;
      $display("FAIL areset_now: got CS=%0d rw=%b led=%b want 0/0/0", CS, CmdRWMaskSet, CmdLEDSet);
    end
    @(posedge C14M);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_timeout();
    int bad; logic [4:0] got, exp;
    apply_reset();
    for (int i = 0; i < 3; i++) bus_cycle(1'b1, keys[i], 1'b0, bad, got, exp);
    for (int i = 0; i < 3; i++) bus_cycle(1'b0, 8'h00, 1'b0, bad, got, exp);
    checks++;
    if (CS !== 3'd3) begin
      errors++;
      $display("FAIL timeout_3idle: got CS=%0d want 3", CS);
    end
    bus_cycle(1'b0, 8'h00, 1'b0, bad, got, exp);
    checks++;
`ifdef RAM2E_CMD_TIMEOUT_EN
    if (CS !== 3'd0) begin
      errors++;
      $display("FAIL timeout_4idle: got CS=%0d want 0", CS);
    end
`else
    if (CS !== 3'd3) begin
      errors++;
      $display("FAIL timeout_4idle: got CS=%0d want 3", CS);
    end
`endif
  endtask

  task automatic test_random();
    int bad; logic [4:0] got, exp;
    int total_bad = 0;
    logic [7:0] d;
    int pick;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 25) begin
        bus_cycle(1'b0, 8'($urandom), 1'($urandom_range(0, 1)), bad, got, exp);
      end else begin
        if (pick < 70 && m_cs < 6) d = keys[m_cs];
        else if (pick < 78) d = 8'h2A;
        else if (pick < 86) d = 8'h28;
        else if (pick < 92) d = 8'hFF;
        else d = 8'($urandom);
        bus_cycle(1'b1, d, 1'($urandom_range(0, 1)), bad, got, exp);
      end
      if (bad != 0) begin
        if (total_bad == 0)
          $display("FAIL random_cycle%0d: got %b want %b", n, got, exp);
        total_bad += bad;
      end
    end
    checks++;
    if (total_bad != 0) begin
      errors++;
      $display("FAIL random_total: got %0d mismatching phases want 0", total_bad);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rwmask();
    test_led();
    test_bad_cmd();
    test_restart();
    test_async_reset();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
